// File: rtl/alu_pkg.sv
// alu_pkg: opcode, flag and FSM state types shared by the sequential ALU slice.
package alu_pkg;
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_INC  = 4'd5,
        OP_MOVA = 4'd6,
        OP_MOVB = 4'd7,
        OP_SHL  = 4'd8,
        OP_SHR  = 4'd9,
        OP_SRA  = 4'd10,
        OP_MUL  = 4'd11
    } op_e;
    typedef struct packed {
        logic c;
        logic v;
        logic n;
        logic z;
    } flags_t;
    typedef enum logic {IDLE, BUSY} state_e;
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand-side and result-side valid/ready bus of the sequential ALU.
interface alu_seq_if #(parameter int BW = 16);
    import alu_pkg::*;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_a;
    logic [BW-1:0] in_b;
    logic [3:0]    opcode;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out;
    flags_t        flags;
    modport master (output in_valid, in_a, in_b, opcode, out_ready,
                    input  in_ready, out_valid, out, flags);
    modport slave  (input  in_valid, in_a, in_b, opcode, out_ready,
                    output in_ready, out_valid, out, flags);
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative signed multiplier, one shift-add step per clock on operand magnitudes.
module alu_mul_seq #(parameter int BW = 16) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [BW-1:0]   a,
    input  logic [BW-1:0]   b,
    output logic            done,
    output logic [2*BW-1:0] p
);
    localparam int CW = $clog2(BW);
    logic [2*BW-1:0] mcand, acc, sum;
    logic [BW-1:0]   mplier, ma, mb;
    logic [CW-1:0]   cnt;
    logic            neg, run;
    assign ma = a[BW-1] ? -a : a;
    assign mb = b[BW-1] ? -b : b;
    // The final step's sum is used combinationally so the result lands on the BW-th edge.
    assign sum  = acc + (mplier[0] ? mcand : '0);
    assign done = run && cnt == CW'(BW - 1);
    assign p    = neg ? -sum : sum;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            run    <= 1'b0;
        end else if (start) begin
            mcand  <= {{BW{1'b0}}, ma};
            mplier <= mb;
            acc    <= '0;
            cnt    <= '0;
            neg    <= a[BW-1] ^ b[BW-1];
            run    <= 1'b1;
        end else if (run) begin
            acc    <= sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            run    <= !done;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered valid/ready ALU with shifts and multi-cycle signed multiply.
// Define ALU_SEQ_SAT_EN to saturate ADD/SUB/INC on overflow instead of wrapping.
module alu_seq #(parameter int BW = 16) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    import alu_pkg::*;
    localparam int SHW = $clog2(BW);
`ifdef ALU_SEQ_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam logic [BW-1:0] MAXP = {1'b0, {(BW-1){1'b1}}};
    localparam logic [BW-1:0] MINN = {1'b1, {(BW-1){1'b0}}};
    state_e          state, state_nx;
    logic [BW-1:0]   a, b, res;
    logic [SHW-1:0]  amt;
    logic [2*BW-1:0] prod;
    flags_t          f, mf;
    logic            accept, start, mul_done, ld_mul, load;
    assign a            = bus.in_a;
    assign b            = bus.in_b;
    assign amt          = b[SHW-1:0];
    assign bus.in_ready = state == IDLE && (!bus.out_valid || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign start        = accept && bus.opcode == OP_MUL;
    alu_mul_seq #(.BW(BW)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .done  (mul_done),
        .p     (prod)
    );
    always_comb begin
        res = '0;
        f   = '0;
        case (bus.opcode)
            OP_ADD: begin
                {f.c, res} = {1'b0, a} + {1'b0, b};
                f.v = a[BW-1] == b[BW-1] && res[BW-1] != a[BW-1];
            end
            OP_SUB: begin
                {f.c, res} = {1'b0, a} - {1'b0, b};
                f.v = a[BW-1] != b[BW-1] && res[BW-1] != a[BW-1];
            end
            OP_INC: begin
                {f.c, res} = {1'b0, a} + 1'b1;
                f.v = a == MAXP;
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_MOVA: res = a;
            OP_MOVB: res = b;
            // An extra guard bit beside the operand catches the last bit shifted out.
            OP_SHL:  {f.c, res} = {1'b0, a} << amt;
            OP_SHR:  {res, f.c} = {a, 1'b0} >> amt;
            OP_SRA:  {res, f.c} = $signed({a, 1'b0}) >>> amt;
            default: res = '0;
        endcase
        if (SAT && f.v) res = res[BW-1] ? MAXP : MINN;
        f.n = res[BW-1];
        f.z = res == '0;
    end
    always_comb begin
        mf   = '0;
        mf.v = !(&prod[2*BW-1:BW-1] || ~|prod[2*BW-1:BW-1]);
        mf.n = prod[BW-1];
        mf.z = prod[BW-1:0] == '0;
    end
    always_comb begin
        state_nx = state;
        ld_mul   = state == BUSY && mul_done;
        state_nx = state == IDLE ? (start ? BUSY : IDLE) : (mul_done ? IDLE : BUSY);
        load     = (accept && !start) || ld_mul;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out       <= '0;
            bus.flags     <= '0;
        end else if (load) begin
            bus.out_valid <= 1'b1;
            bus.out       <= ld_mul ? prod[BW-1:0] : res;
            bus.flags     <= ld_mul ? mf : f;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule
